// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Shared constants, mode encodings and sequencer state type.
//  Revision : 1.0
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W   = 4;
    localparam int DUTY_MAX = 15;

    localparam logic [1:0] MODE_STATIC  = 2'b00;
    localparam logic [1:0] MODE_TRI     = 2'b01;
    localparam logic [1:0] MODE_SAW     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_fade_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_fade_sequencer_if
//  Brief    : User controls in, duty command and status out.
//  Revision : 1.0
// ============================================================================
interface pwm_fade_sequencer_if #(
    parameter int DUTY_W = pwm_pkg::DUTY_W
);
    logic              enable;
    logic [1:0]        mode;
    logic [DUTY_W-1:0] static_duty;
    logic [DUTY_W-1:0] duty_cyc;
    logic              duty_upd;
    logic              busy;
    logic              cycle_done;

    modport master (
        output enable, mode, static_duty,
        input  duty_cyc, duty_upd, busy, cycle_done
    );

    modport slave (
        input  enable, mode, static_duty,
        output duty_cyc, duty_upd, busy, cycle_done
    );
endinterface
`default_nettype wire

// File: rtl/pwm_step_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_step_prescaler
//  Brief    : Free-running step divider; tick once every STEP_CYCLES while run.
//  Revision : 1.0
// ============================================================================
module pwm_step_prescaler #(
    parameter int STEP_CYCLES = 10000000,
    parameter int CNT_W       = 27
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic run,
    output logic      tick
);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_fade_sequencer
//  Brief    : Sequences the PWM duty command through triangle, sawtooth and
//             single-shot fade patterns, or passes a static duty through.
//  Revision : 1.0
// ============================================================================
module pwm_fade_sequencer #(
    parameter int DUTY_W      = pwm_pkg::DUTY_W,
    parameter int DUTY_MAX    = pwm_pkg::DUTY_MAX,
    parameter int STEP_CYCLES = 10000000,
    parameter int HOLD_STEPS  = 4,
    parameter int CNT_W       = 27
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pwm_fade_sequencer_if.slave    bus
);
    import pwm_pkg::*;

    localparam int                HOLD_W     = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    localparam logic [DUTY_W-1:0] c_DUTY_TOP = DUTY_W'(DUTY_MAX);

    seq_state_t        r_state, w_state_nxt;
    logic [DUTY_W-1:0] r_duty,  w_duty_nxt;
    logic              r_upd,   w_upd_nxt;
    logic              r_cdone, w_cdone_nxt;
    logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
    logic [1:0]        r_mode,  w_mode_nxt;
    logic              w_busy;
    logic              w_tick;

    pwm_step_prescaler #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == ST_IDLE),
        .run   (w_busy),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_upd   <= 1'b0;
            r_cdone <= 1'b0;
            r_hold  <= '0;
            r_mode  <= MODE_STATIC;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_upd   <= w_upd_nxt;
            r_cdone <= w_cdone_nxt;
            r_hold  <= w_hold_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_upd_nxt   = 1'b0;
        w_cdone_nxt = 1'b0;
        w_hold_nxt  = r_hold;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable && (bus.mode != MODE_STATIC)) begin
                    // Entry always announces duty 0, even if already 0.
                    w_mode_nxt  = bus.mode;
                    w_duty_nxt  = '0;
                    w_upd_nxt   = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_UP;
                end else begin
                    w_duty_nxt = bus.static_duty;
                    w_upd_nxt  = (bus.static_duty != r_duty);
                end
            end
            ST_UP: begin
                if (w_tick) begin
                    if (r_duty < c_DUTY_TOP) begin
                        w_duty_nxt = r_duty + 1'b1;
                        w_upd_nxt  = 1'b1;
                    end else begin
                        case (r_mode)
                            MODE_TRI: w_state_nxt = (HOLD_STEPS == 0) ? ST_DOWN : ST_HOLD_HI;
                            MODE_SAW: begin
                                w_duty_nxt  = '0;
                                w_upd_nxt   = 1'b1;
                                w_cdone_nxt = 1'b1;
                            end
                            default: begin
                                w_state_nxt = ST_DONE;
                                w_cdone_nxt = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_HOLD_HI: begin
                if (w_tick) begin
                    if (r_hold == c_HOLD_LST) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_DOWN;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (w_tick) begin
                    if (r_duty != '0) begin
                        w_duty_nxt = r_duty - 1'b1;
                        w_upd_nxt  = 1'b1;
                    end else if (HOLD_STEPS == 0) begin
                        w_state_nxt = ST_UP;
                        w_cdone_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD_LO;
                    end
                end
            end
            ST_HOLD_LO: begin
                if (w_tick) begin
                    if (r_hold == c_HOLD_LST) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_UP;
                        w_cdone_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            ST_DONE: ;
            default: w_state_nxt = ST_IDLE;
        endcase
        // Dropping enable wins over any coincident tick and suppresses completion.
        if ((r_state != ST_IDLE) && !bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = bus.static_duty;
            w_upd_nxt   = (bus.static_duty != r_duty);
            w_cdone_nxt = 1'b0;
            w_hold_nxt  = '0;
        end
    end

    always_comb begin
        w_busy = (r_state == ST_UP) || (r_state == ST_HOLD_HI) ||
                 (r_state == ST_DOWN) || (r_state == ST_HOLD_LO);
    end

    assign bus.duty_cyc   = r_duty;
    assign bus.duty_upd   = r_upd;
    assign bus.busy       = w_busy;
    assign bus.cycle_done = r_cdone;
endmodule
`default_nettype wire
